// File: rtl/alu_pkg.sv
// Shared ALU definitions: control codes, divider states and constants.
// Imported by the execute-stage arithmetic blocks.
package alu_pkg;

    typedef enum logic [2:0] {
        IDLE,
        PREP,
        ITER,
        FIX,
        DONE
    } div_state_e;

    localparam logic [3:0] ALU_DIVU = 4'b1100;
    localparam logic [3:0] ALU_DIV  = 4'b1101;

    localparam int DATA_W = 32;

    localparam logic [DATA_W-1:0] DIV_ZERO_QUOT = '1;
    localparam logic [DATA_W-1:0] SIGNED_MIN =
        {1'b1, {(DATA_W-1){1'b0}}};

endpackage

// File: rtl/alu_divider_step.sv
// One restoring division iteration: shift in the next dividend bit,
// trial-subtract the divisor and keep the difference if non-negative.
module div_step #(
    parameter int WIDTH = 32
) (
    input  logic [WIDTH-1:0] rem,
    input  logic             msb,
    input  logic [WIDTH-1:0] divisor,
    output logic [WIDTH-1:0] rem_next,
    output logic             q_bit
);

    logic [WIDTH:0] shifted;
    logic [WIDTH:0] trial;

    assign shifted  = {rem, msb};
    assign trial    = shifted - {1'b0, divisor};
    assign q_bit    = ~trial[WIDTH];
    assign rem_next = q_bit ? trial[WIDTH-1:0]
                            : shifted[WIDTH-1:0];

endmodule

// File: rtl/alu_divider.sv
// Multi-cycle restoring divider beside the execute-stage ALU.
// Magnitudes are divided unsigned; signs are fixed up in FIX.
module alu_divider
    import alu_pkg::*;
#(
    parameter int WIDTH = DATA_W,
    parameter int CNT_W = 6
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic             signed_op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] quotient,
    output logic [WIDTH-1:0] remainder,
    output logic             zero_flag,
    output logic             sign_flag,
    output logic             div_by_zero,
    output logic             overflow_flag
);

    localparam logic [WIDTH-1:0] ALL1  = '1;
    localparam logic [WIDTH-1:0] MIN_V =
        {1'b1, {(WIDTH-1){1'b0}}};

    div_state_e state, state_nxt;

    logic [WIDTH-1:0] a_q, b_q;
    logic [WIDTH-1:0] rem_q, dvd_q, dvs_q;
    logic             sgn_q;
    logic [CNT_W-1:0] cnt_q;

    logic             is_zero, is_ovf;
    logic             a_neg, b_neg;
    logic [WIDTH-1:0] step_rem;
    logic             step_q;
    logic [WIDTH-1:0] fix_q, fix_r;

    assign is_zero = (b_q == '0);
    assign is_ovf  = sgn_q && (a_q == MIN_V)
                     && (b_q == ALL1);
    assign a_neg   = sgn_q & a_q[WIDTH-1];
    assign b_neg   = sgn_q & b_q[WIDTH-1];

    assign busy = (state != IDLE);
    assign done = (state == DONE);

    div_step #(.WIDTH(WIDTH)) u_step (
        .rem      (rem_q),
        .msb      (dvd_q[WIDTH-1]),
        .divisor  (dvs_q),
        .rem_next (step_rem),
        .q_bit    (step_q)
    );

    always_comb begin
        fix_q = dvd_q;
        fix_r = rem_q;
        unique case (1'b1)
            is_zero: begin
                fix_q = ALL1;
                fix_r = a_q;
            end
            is_ovf: begin
                fix_q = MIN_V;
                fix_r = '0;
            end
            default: begin
                if (a_neg ^ b_neg) fix_q = -dvd_q;
                if (a_neg)         fix_r = -rem_q;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        unique case (state)
            IDLE: if (start) state_nxt = PREP;
            PREP: state_nxt = (is_zero || is_ovf)
                              ? FIX : ITER;
            ITER: if (cnt_q == CNT_W'(1))
                      state_nxt = FIX;
            FIX:  state_nxt = DONE;
            DONE: state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            a_q           <= '0;
            b_q           <= '0;
            sgn_q         <= 1'b0;
            rem_q         <= '0;
            dvd_q         <= '0;
            dvs_q         <= '0;
            cnt_q         <= '0;
            quotient      <= '0;
            remainder     <= '0;
            zero_flag     <= 1'b0;
            sign_flag     <= 1'b0;
            div_by_zero   <= 1'b0;
            overflow_flag <= 1'b0;
        end else begin
            unique case (state)
                IDLE: if (start) begin
                    a_q   <= a;
                    b_q   <= b;
                    sgn_q <= signed_op;
                end
                PREP: begin
                    dvd_q <= a_neg ? -a_q : a_q;
                    dvs_q <= b_neg ? -b_q : b_q;
                    rem_q <= '0;
                    cnt_q <= CNT_W'(WIDTH);
                end
                ITER: begin
                    rem_q <= step_rem;
                    dvd_q <= {dvd_q[WIDTH-2:0], step_q};
                    cnt_q <= cnt_q - CNT_W'(1);
                end
                FIX: begin
                    quotient      <= fix_q;
                    remainder     <= fix_r;
                    zero_flag     <= (fix_q == '0);
                    sign_flag     <= fix_q[WIDTH-1];
                    div_by_zero   <= is_zero;
                    overflow_flag <= is_ovf;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: doc/alu_divider.md
Name: alu_divider

Overview:
- Multi-cycle integer divider; the inverse of the ALU's combinational multiply path (control 1010/1011).
- Sits beside the ALU in the execute stage. Operates on the same 32-bit operand buses.
- Returns quotient/remainder on two result buses, matching the ALU's result_1/result_2 pairing.
- Uses a start/busy/done handshake so the pipeline controller can stall for the iteration cycles.

Parameters:
- WIDTH, 32: operand and result width in bits.
- CNT_W, 6: iteration counter width; must be at least clog2(WIDTH)+1.

Ports:
- clk  in  1  system clock; all state updates on the rising edge.
- rst_n  in  1  asynchronous active-low reset.
- start  in  1  request pulse; sampled only in IDLE.
- signed_op  in  1  1 = signed divide (DIV), 0 = unsigned divide (DIVU); captured with start.
- a  in  WIDTH  dividend; captured with start.
- b  in  WIDTH  divisor; captured with start.
- busy  out  1  high from the cycle after start is accepted until done is asserted, inclusive.
- done  out  1  one-cycle pulse; results are valid from this cycle.
- quotient  out  WIDTH  quotient; truncated toward zero.
- remainder  out  WIDTH  remainder; its sign follows the dividend.
- zero_flag  out  1  quotient == 0.
- sign_flag  out  1  quotient[WIDTH-1].
- div_by_zero  out  1  divisor was 0.
- overflow_flag  out  1  signed MIN / -1 case.

Behaviour:
- Reset (asynchronous, any state):
  - State returns to IDLE.
  - busy, done, quotient, remainder and all flags go to 0.
  - An in-flight operation is discarded; no done pulse is produced for it.
- States:
  - IDLE: start=1 captures a, b and signed_op, then moves to PREP. start=0 stays in IDLE.
  - PREP (1 cycle):
    - b==0: go to FIX.
    - signed_op and a==MIN and b==all-ones: go to FIX.
    - Otherwise: load the magnitudes of a and b (absolute value when signed_op; raw values when unsigned), clear the partial remainder, set counter=WIDTH, go to ITER.
  - ITER (exactly WIDTH cycles): one restoring step per cycle.
    - Shift {partial remainder, dividend} left by 1.
    - Trial-subtract the divisor magnitude.
    - If the trial is non-negative, keep the difference and shift in quotient bit 1; otherwise restore and shift in 0.
    - Decrement the counter; at counter 1, go to FIX.
  - FIX (1 cycle): sign correction and special cases, all registered.
    - Normal signed: negate the quotient if sign(a)!=sign(b); negate the remainder if a is negative.
    - b==0: quotient=all-ones, remainder=a, div_by_zero=1.
    - Signed MIN/-1: quotient=MIN, remainder=0, overflow_flag=1.
    - zero_flag and sign_flag are computed from the final quotient.
    - Go to DONE.
  - DONE (1 cycle): done=1, then return to IDLE.
- Latency, with start accepted at rising edge N:
  - Normal operation: done is high in the cycle after edge N+WIDTH+2 (34 clocks for WIDTH=32).
  - Special cases (b==0, MIN/-1): done is high in the cycle after edge N+2.
- busy is asserted in PREP, ITER, FIX and DONE. It is 0 in IDLE.
- start while busy is ignored; it is neither queued nor allowed to corrupt operands. start in the same cycle as done is also ignored.
- Outputs hold their last values after done until the next accepted start. They are not cleared on start.
- No carry flag; the divider never produces carry-out.
- Unsigned mode never sets overflow_flag.

Decomposition:
- Shared package alu_pkg holds:
  - the divider state enum (IDLE, PREP, ITER, FIX, DONE);
  - new ALU control codes extending the existing 4-bit map: 4'b1100 = DIVU, 4'b1101 = DIV;
  - constants DIV_ZERO_QUOT = all-ones and SIGNED_MIN = 1 followed by zeros.
- One natural sub-module, div_step: a combinational single restoring iteration.
  - Inputs: partial remainder, dividend MSB, divisor.
  - Outputs: next partial remainder, quotient bit.
  - Instantiated once inside the ITER datapath.

Test Plan:
- Unsigned 100 / 7 -> quotient=14, remainder=2, flags 0, done exactly 34 clocks after start; busy high for all 34 of those cycles.
- Signed 0xFFFFFFF9 (-7) / 2 -> quotient=0xFFFFFFFD (-3), remainder=0xFFFFFFFF (-1), sign_flag=1. Signed 7 / -2 -> quotient=0xFFFFFFFD, remainder=1.
- Divide by zero, 5 / 0 in both modes -> quotient=0xFFFFFFFF, remainder=5, div_by_zero=1, done 2 clocks after start.
- Signed 0x80000000 / 0xFFFFFFFF -> quotient=0x80000000, remainder=0, overflow_flag=1. The same operands unsigned -> quotient=0, remainder=0x80000000, zero_flag=1, overflow_flag=0.
- Start pulsed with new operands at cycle 10 of a busy operation -> first result is unaffected and no second done follows. Start in the done cycle is also ignored.
- rst_n low at cycle 15 of an operation -> all outputs 0 immediately (asynchronously), no done. A fresh 0xFFFFFFFF / 1 unsigned then yields quotient=0xFFFFFFFF, remainder=0.
